ifu_ctl: RTL and testbench
==========================

Name: ifu_ctl

Overview:
- Fetch sequencer for the instruction fetch unit. It drives the PC write controls (write enable, source select, increment size) into the ifu.
- It runs one instruction-memory request/acknowledge transaction per instruction and hands each fetched word to decode with a valid/ready handshake.
- It chooses the next-PC source from the execute result: sequential, branch/jump target, or trap vector.
- It sits between ifu, the instruction-memory port and the decode/execute stage, and runs one instruction at a time (non-pipelined).

Parameters:
- XLEN, 32, datapath width; instruction word is fixed at 32 bits.
- TMO_W, 8, width of the fetch-timeout counter; a request unacknowledged for 2^TMO_W-1 cycles is a fault.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- run_i  in  1  enable fetching; level-sensitive
- imem_req_o  out  1  instruction-memory request; held until ack or err
- imem_ack_i  in  1  request completed; imem_rdata_i valid this cycle
- imem_err_i  in  1  bus error terminating the request
- imem_rdata_i  in  32  fetched instruction word
- inst_valid_o  out  1  inst_data_o holds an instruction for decode
- inst_data_o  out  32  latched instruction word
- inst_ready_i  in  1  execute finished the instruction; br_taken_i and trap_i are sampled with it
- br_taken_i  in  1  next PC = ALU target
- trap_i  in  1  next PC = trap vector
- pc_wr_en_o  out  1  PC write strobe to ifu
- pc_wr_sel_o  out  2  PC source: 00 sequential (pc_next), 01 ALU target, 10 trap vector, 11 reserved (never driven)
- pc_inc_sel_o  out  1  increment size: 0 = +4, 1 = +2 (compressed)
- fetch_fault_o  out  1  one-cycle pulse on fetch error or timeout
- busy_o  out  1  state != IDLE

Behaviour:
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Reset values: state IDLE; all 1-bit outputs 0; pc_wr_sel_o 00; inst_data_o 0; timeout counter 0.
- Reset asserted mid-operation aborts everything, including an outstanding request, and returns to IDLE. No PC write is issued.
- States: IDLE, REQ, ISSUE, UPDATE, FAULT.
- IDLE:
  - run_i=1 goes to REQ the next cycle.
- REQ:
  - imem_req_o=1; the timeout counter increments each cycle.
  - imem_ack_i (priority over imem_err_i): latch imem_rdata_i into inst_data_o. Latch pc_inc_sel_o = (rdata[1:0] != 2'b11). Go to ISSUE.
  - imem_err_i, or counter reaching 2^TMO_W-1: go to FAULT.
  - The counter clears on leaving REQ.
  - run_i deasserting during REQ does not abort; the bus transaction always completes.
- ISSUE:
  - inst_valid_o=1, held until inst_ready_i; inst_data_o is stable while valid.
  - On inst_ready_i, register sel: trap_i -> 10, else br_taken_i -> 01, else 00. trap_i has priority when both are set. Go to UPDATE.
- UPDATE:
  - pc_wr_en_o=1 for exactly one cycle; the PC is updated at the end of this cycle.
  - Next state: run_i ? REQ : IDLE.
  - Fetch-to-fetch minimum: REQ(1, ack same cycle) + ISSUE(1) + UPDATE(1) = 3 cycles per instruction.
- FAULT:
  - fetch_fault_o=1, pc_wr_en_o=1, pc_wr_sel_o=10, pc_inc_sel_o=0, all for one cycle.
  - Next state: run_i ? REQ : IDLE.
- pc_wr_sel_o and pc_inc_sel_o hold their last values when pc_wr_en_o=0.
- imem_ack_i or imem_err_i outside REQ is ignored. inst_ready_i outside ISSUE is ignored.

Test Plan:
- Reset, then run_i=1 with ack on the first REQ cycle, rdata=0x00000013, ready next cycle, no branch -> imem_req_o 1 cycle, inst_valid_o 1 cycle, then pc_wr_en_o=1 with sel=00 and inc=0. Next REQ follows 3 cycles after the first.
- Ack delayed 5 cycles, rdata=0x00004501 (compressed), ready with br_taken_i=1 -> imem_req_o held 6 cycles, inc=1, sel=01 in UPDATE.
- Ready with trap_i=1 and br_taken_i=1 together -> sel=10.
- imem_err_i in REQ -> one-cycle fetch_fault_o with pc_wr_en_o=1 and sel=10, then REQ.
- TMO_W=3, no ack -> fault after 7 REQ cycles.
- run_i dropped mid-REQ -> ack still honored, instruction issued, UPDATE, then IDLE with busy_o=0.
- rst_i asserted while in ISSUE -> all outputs 0 immediately; no pc_wr_en_o pulse occurs.

Source files
------------

// File: rtl/ifu_ctl.sv
// Fetch sequencer: one imem transaction per instruction, decode handshake,
// and next-PC source selection into the ifu.
module ifu_ctl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TMO_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  input  logic        inst_ready_i,
  input  logic        br_taken_i,
  input  logic        trap_i,
  output logic        pc_wr_en_o,
  output logic [1:0]  pc_wr_sel_o,
  output logic        pc_inc_sel_o,
  output logic        fetch_fault_o,
  output logic        busy_o
);

  localparam int unsigned ILEN = (XLEN > 32) ? 32 : XLEN;
  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    UPDATE,
    FAULT
  } state_e;

  state_e           state_q;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic [ILEN-1:0]  data_q;
  logic [1:0]       sel_q;
  logic             inc_q;

  assign cnt_d = cnt_q + TMO_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sel_q   <= SEL_SEQ;
      inc_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run_i) state_q <= REQ;
        end
        REQ: begin
          if (imem_ack_i) begin
            data_q  <= imem_rdata_i[ILEN-1:0];
            // Low bits other than 11 mark a 16-bit compressed instruction
            inc_q   <= (imem_rdata_i[1:0] != 2'b11);
            cnt_q   <= '0;
            state_q <= ISSUE;
          end else if (imem_err_i || cnt_d == CNT_MAX) begin
            cnt_q   <= '0;
            sel_q   <= SEL_TRAP;
            inc_q   <= 1'b0;
            state_q <= FAULT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ISSUE: begin
          if (inst_ready_i) begin
            sel_q   <= trap_i     ? SEL_TRAP :
                       br_taken_i ? SEL_ALU  : SEL_SEQ;
            state_q <= UPDATE;
          end
        end
        UPDATE, FAULT: begin
          state_q <= run_i ? REQ : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign inst_valid_o  = (state_q == ISSUE);
  assign inst_data_o   = data_q;
  assign pc_wr_en_o    = (state_q == UPDATE) || (state_q == FAULT);
  assign pc_wr_sel_o   = sel_q;
  assign pc_inc_sel_o  = inc_q;
  assign fetch_fault_o = (state_q == FAULT);
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ifu_ctl.sv
// Self-checking bench for ifu_ctl: scenario tasks with a scoreboard
// of expected PC-update results.
module tb_ifu_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        ready;
  logic        br;
  logic        trap;
  logic        imem_req_o;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic        pc_wr_en_o;
  logic [1:0]  pc_wr_sel_o;
  logic        pc_inc_sel_o;
  logic        fetch_fault_o;
  logic        busy_o;

  int vec = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        inc;
    logic [1:0]  sel;
    logic        flt;
  } exp_t;

  exp_t sb[$];

  ifu_ctl #(.XLEN(32), .TMO_W(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (ack),
    .imem_err_i   (err),
    .imem_rdata_i (rdata),
    .inst_valid_o (inst_valid_o),
    .inst_data_o  (inst_data_o),
    .inst_ready_i (ready),
    .br_taken_i   (br),
    .trap_i       (trap),
    .pc_wr_en_o   (pc_wr_en_o),
    .pc_wr_sel_o  (pc_wr_sel_o),
    .pc_inc_sel_o (pc_inc_sel_o),
    .fetch_fault_o(fetch_fault_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [1:0] s,
                              input logic f);
    exp_t x;
    x.data = d;
    x.inc  = f ? 1'b0 : (d[1:0] != 2'b11);
    x.sel  = s;
    x.flt  = f;
    return x;
  endfunction

  // Drives one bus transaction and decode handshake, reports observations.
  task automatic fetch(
    input  int          d,
    input  logic        e,
    input  logic [31:0] rd,
    input  logic        b,
    input  logic        t,
    input  logic        drop,
    output logic        ok,
    output int          nreq,
    output int          nval,
    output logic [31:0] dat,
    output logic        dstab,
    output logic        wen,
    output logic        flt,
    output logic [1:0]  sel,
    output logic        inc,
    output logic        nxt_req,
    output logic        nxt_busy
  );
    int w;
    ok = 1'b1; nreq = 0; nval = 0; dat = '0; dstab = 1'b1;
    wen = 1'b0; flt = 1'b0; sel = 2'b11; inc = 1'b0;
    nxt_req = 1'b0; nxt_busy = 1'b0;
    run = 1'b1;
    w = 0;
    while (!imem_req_o && w < 10) begin
      step();
      w++;
    end
    if (!imem_req_o) begin
      ok = 1'b0;
      return;
    end
    while (imem_req_o && nreq < 40) begin
      nreq++;
      if (drop) run = 1'b0;
      if (nreq == d + 1) begin
        ack = !e; err = e; rdata = rd;
      end
      step();
      ack = 1'b0; err = 1'b0; rdata = 32'hdead_beef;
    end
    if (imem_req_o) ok = 1'b0;
    dat = inst_data_o;
    while (inst_valid_o && nval < 40) begin
      nval++;
      if (inst_data_o !== dat) dstab = 1'b0;
      ready = 1'b1; br = b; trap = t;
      step();
      ready = 1'b0; br = 1'b0; trap = 1'b0;
    end
    if (inst_valid_o) ok = 1'b0;
    wen = pc_wr_en_o; flt = fetch_fault_o;
    sel = pc_wr_sel_o; inc = pc_inc_sel_o;
    step();
    nxt_req = imem_req_o; nxt_busy = busy_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; ack = 1'b0; err = 1'b0;
    rdata = '0; ready = 1'b0; br = 1'b0; trap = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    vec++;
    if ({imem_req_o, inst_valid_o, pc_wr_en_o, fetch_fault_o, busy_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 00000",
               {imem_req_o, inst_valid_o, pc_wr_en_o, fetch_fault_o, busy_o});
    end
    vec++;
    if ({pc_wr_sel_o, pc_inc_sel_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_sel got %b want 000", {pc_wr_sel_o, pc_inc_sel_o});
    end
    vec++;
    if (inst_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got %h want 0", inst_data_o);
    end
  endtask

  task automatic test_basic();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0000_0013, 2'b00, 1'b0));
    fetch(0, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b0,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || nreq !== 1 || nval !== 1) begin
      bad++;
      $display("FAIL basic_cycles got ok=%0b req=%0d val=%0d want 1/1/1",
               ok, nreq, nval);
    end
    vec++;
    if ({dat, inc, sel, wen, flt} !== {x.data, x.inc, x.sel, 1'b1, x.flt}) begin
      bad++;
      $display("FAIL basic_update got d=%h inc=%b sel=%b wen=%b flt=%b want d=%h inc=%b sel=%b wen=1 flt=%b",
               dat, inc, sel, wen, flt, x.data, x.inc, x.sel, x.flt);
    end
    vec++;
    if (nreq + nval + 1 !== 3 || nr !== 1'b1) begin
      bad++;
      $display("FAIL basic_f2f got %0d cycles req=%b want 3 req=1",
               nreq + nval + 1, nr);
    end
  endtask

  task automatic test_branch_compressed();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0000_4501, 2'b01, 1'b0));
    fetch(5, 1'b0, 32'h0000_4501, 1'b1, 1'b0, 1'b0,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || nreq !== 6) begin
      bad++;
      $display("FAIL branch_req_hold got ok=%0b req=%0d want 6", ok, nreq);
    end
    vec++;
    if ({dat, inc, sel, wen} !== {x.data, x.inc, x.sel, 1'b1} || !ds) begin
      bad++;
      $display("FAIL branch_update got d=%h inc=%b sel=%b wen=%b stab=%b want d=%h inc=%b sel=%b",
               dat, inc, sel, wen, ds, x.data, x.inc, x.sel);
    end
  endtask

  task automatic test_trap_priority();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0010_0073, 2'b10, 1'b0));
    fetch(1, 1'b0, 32'h0010_0073, 1'b1, 1'b1, 1'b0,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || {sel, inc, wen, flt} !== {x.sel, x.inc, 1'b1, x.flt}) begin
      bad++;
      $display("FAIL trap_sel got ok=%0b sel=%b inc=%b wen=%b flt=%b want sel=%b inc=%b",
               ok, sel, inc, wen, flt, x.sel, x.inc);
    end
  endtask

  task automatic test_bus_error();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0, 2'b10, 1'b1));
    fetch(0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || nreq !== 1 || nval !== 0) begin
      bad++;
      $display("FAIL err_cycles got ok=%0b req=%0d val=%0d want 1/0",
               ok, nreq, nval);
    end
    vec++;
    if ({flt, wen, sel, inc} !== {x.flt, 1'b1, x.sel, x.inc}) begin
      bad++;
      $display("FAIL err_fault got flt=%b wen=%b sel=%b inc=%b want 1 1 %b %b",
               flt, wen, sel, inc, x.sel, x.inc);
    end
    vec++;
    if (nr !== 1'b1) begin
      bad++;
      $display("FAIL err_next_req got %b want 1", nr);
    end
  endtask

  task automatic test_timeout();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0, 2'b10, 1'b1));
    fetch(100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || nreq !== 7) begin
      bad++;
      $display("FAIL tmo_cycles got ok=%0b req=%0d want 7", ok, nreq);
    end
    vec++;
    if ({flt, wen, sel, inc} !== {x.flt, 1'b1, x.sel, x.inc}) begin
      bad++;
      $display("FAIL tmo_fault got flt=%b wen=%b sel=%b inc=%b want 1 1 %b %b",
               flt, wen, sel, inc, x.sel, x.inc);
    end
  endtask

  task automatic test_run_drop();
    logic ok, ds, wen, flt, inc, nr, nb;
    int nreq, nval;
    logic [31:0] dat;
    logic [1:0] sel;
    exp_t x;
    sb.push_back(mk(32'h0000_0033, 2'b00, 1'b0));
    fetch(2, 1'b0, 32'h0000_0033, 1'b0, 1'b0, 1'b1,
          ok, nreq, nval, dat, ds, wen, flt, sel, inc, nr, nb);
    x = sb.pop_front();
    vec++;
    if (!ok || nreq !== 3 || nval !== 1 || dat !== x.data) begin
      bad++;
      $display("FAIL drop_issue got ok=%0b req=%0d val=%0d d=%h want 3/1 d=%h",
               ok, nreq, nval, dat, x.data);
    end
    vec++;
    if ({wen, sel, inc} !== {1'b1, x.sel, x.inc}) begin
      bad++;
      $display("FAIL drop_update got wen=%b sel=%b inc=%b want 1 %b %b",
               wen, sel, inc, x.sel, x.inc);
    end
    vec++;
    if ({nr, nb} !== 2'b00) begin
      bad++;
      $display("FAIL drop_idle got req=%b busy=%b want 0 0", nr, nb);
    end
  endtask

  task automatic test_reset_in_issue();
    int wens;
    run = 1'b1;
    step();
    ack = 1'b1; rdata = 32'h0000_0093;
    step();
    ack = 1'b0;
    vec++;
    if (inst_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_issue got valid=%b want 1", inst_valid_o);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({imem_req_o, inst_valid_o, pc_wr_en_o, fetch_fault_o, busy_o,
         pc_wr_sel_o, pc_inc_sel_o} !== 8'b0 || inst_data_o !== 32'h0) begin
      bad++;
      $display("FAIL rst_async got flags=%b d=%h want 0",
               {imem_req_o, inst_valid_o, pc_wr_en_o, fetch_fault_o, busy_o,
                pc_wr_sel_o, pc_inc_sel_o}, inst_data_o);
    end
    run = 1'b0; ready = 1'b1;
    wens = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) rst = 1'b0;
      if (pc_wr_en_o) wens++;
    end
    ready = 1'b0;
    vec++;
    if (wens !== 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_write got wen_pulses=%0d busy=%b want 0 0",
               wens, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_compressed();
    test_trap_priority();
    test_bus_error();
    test_timeout();
    test_run_drop();
    test_reset_in_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
